// File: rtl/regfile_locked.sv
// Dual-read, single-write register file whose upper address region can only be
// written once per key-sequence unlock (KEY followed by ~KEY on consecutive cycles).
module regfile_locked #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned PROT_BASE  = 12,
    parameter logic [15:0] KEY        = 16'h0032,
    parameter int unsigned UNLOCK_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              key_valid,
    input  logic [15:0]       key_in,
    output logic              key_access,
    output logic              wr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] ST_LOCKED   = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_UNLOCKED = 2'd2;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              wr_err_nxt;
    logic              key_access_nxt;
    logic              wr_prot_c;
    logic              wr_legal_c;
    logic              byp0_c;
    logic              byp1_c;

    // Write qualification; address 0 is never written and never flags an error.
    always_comb begin
        wr_prot_c  = 32'(wr_addr) >= PROT_BASE;
        wr_legal_c = wr_en && (wr_addr != '0) && (!wr_prot_c || (state == ST_UNLOCKED));
        byp0_c     = wr_legal_c && (wr_addr == rd_addr0);
        byp1_c     = wr_legal_c && (wr_addr == rd_addr1);
    end

    // Lock FSM next-state and registered-output decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        wr_err_nxt = wr_en && (wr_addr != '0) && wr_prot_c && (state != ST_UNLOCKED);
        case (state)
            ST_LOCKED: begin
                cnt_nxt = '0;
                if (key_valid && (key_in == KEY)) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (key_valid && (key_in == ~KEY)) begin
                    state_nxt = ST_UNLOCKED;
                    cnt_nxt   = CNT_W'(UNLOCK_CYC);
                end else begin
                    state_nxt = ST_LOCKED;
                    cnt_nxt   = '0;
                end
            end
            ST_UNLOCKED: begin
                cnt_nxt = cnt - CNT_W'(1);
                // One protected write per unlock; any key activity aborts the window.
                if (key_valid || (wr_legal_c && wr_prot_c) || (cnt <= CNT_W'(1))) begin
                    state_nxt = ST_LOCKED;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_LOCKED;
                cnt_nxt   = '0;
            end
        endcase
        key_access_nxt = (state_nxt == ST_UNLOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LOCKED;
            cnt        <= '0;
            wr_err     <= 1'b0;
            key_access <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wr_err     <= wr_err_nxt;
            key_access <= key_access_nxt;
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_legal_c) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Registered read ports with same-cycle write bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data0 <= '0;
            rd_data1 <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data0 <= byp0_c ? wr_data : regs[rd_addr0];
                rd_data1 <= byp1_c ? wr_data : regs[rd_addr1];
            end
        end
    end

endmodule

// File: tb/tb_regfile_locked.sv
// Directed vector bench for regfile_locked: per-cycle table plus reset corner sequences.
module tb_regfile_locked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [3:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        key_valid;
    logic [15:0] key_in;
    logic        key_access;
    logic        wr_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rd_en;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic        wr_en;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        kv;
        logic [15:0] key;
        logic        e_rv;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic        e_ka;
        logic        e_err;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    regfile_locked dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rd_data0   (rd_data0),
        .rd_data1   (rd_data1),
        .rd_valid   (rd_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_access (key_access),
        .wr_err     (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rv, input logic [31:0] d0,
                           input logic [31:0] d1, input logic ka, input logic err);
        chk({tag, " rd_valid"},   32'(rd_valid),   32'(rv));
        chk({tag, " rd_data0"},   rd_data0,        d0);
        chk({tag, " rd_data1"},   rd_data1,        d1);
        chk({tag, " key_access"}, 32'(key_access), 32'(ka));
        chk({tag, " wr_err"},     32'(wr_err),     32'(err));
    endtask

    task automatic add(input logic re, input logic [3:0] a0, input logic [3:0] a1,
                       input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic kv, input logic [15:0] key,
                       input logic rv, input logic [31:0] d0, input logic [31:0] d1,
                       input logic ka, input logic err);
        vecs[nv] = '{re, a0, a1, we, wa, wd, kv, key, rv, d0, d1, ka, err};
        nv++;
    endtask

    task automatic drive(input logic re, input logic [3:0] a0, input logic [3:0] a1,
                         input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic kv, input logic [15:0] key);
        rd_en = re; rd_addr0 = a0; rd_addr1 = a1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        key_valid = kv; key_in = key;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 16'h0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //  re a0 a1  we wa  wd            kv key       rv d0            d1            ka err
        add(0, 0, 0,  1, 3,  32'hDEADBEEF, 0, 16'h0000, 0, 32'h0,        32'h0,        0, 0);
        add(1, 3, 3,  0, 0,  32'h0,        0, 16'h0000, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        add(0, 0, 0,  1, 13, 32'h11111111, 0, 16'h0000, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
        add(1, 13, 3, 0, 0,  32'h0,        0, 16'h0000, 1, 32'h0,        32'hDEADBEEF, 0, 0);
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'h0032, 0, 32'h0,        32'hDEADBEEF, 0, 0);
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'hFFCD, 0, 32'h0,        32'hDEADBEEF, 1, 0);
        add(1, 13, 13, 1, 13, 32'h12345678, 0, 16'h0000, 1, 32'h12345678, 32'h12345678, 0, 0);
        add(1, 14, 13, 1, 14, 32'h22222222, 0, 16'h0000, 1, 32'h0,        32'h12345678, 0, 1);
        add(0, 0, 0,  0, 0,  32'h0,        0, 16'h0000, 0, 32'h0,        32'h12345678, 0, 0);
        // timed window: high for exactly 8 cycles after the unlocking edge
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'h0032, 0, 32'h0,        32'h12345678, 0, 0);
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'hFFCD, 0, 32'h0,        32'h12345678, 1, 0);
        for (int i = 0; i < 7; i++)
            add(0, 0, 0, 0, 0, 32'h0,      0, 16'h0000, 0, 32'h0,        32'h12345678, 1, 0);
        add(0, 0, 0,  0, 0,  32'h0,        0, 16'h0000, 0, 32'h0,        32'h12345678, 0, 0);
        add(0, 0, 0,  1, 15, 32'h33333333, 0, 16'h0000, 0, 32'h0,        32'h12345678, 0, 1);
        add(1, 15, 0, 0, 0,  32'h0,        0, 16'h0000, 1, 32'h0,        32'h0,        0, 0);
        // bypass, and address-0 write never bypasses
        add(1, 5, 5,  1, 5,  32'hA5A5A5A5, 0, 16'h0000, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
        add(1, 5, 0,  1, 0,  32'hFFFFFFFF, 0, 16'h0000, 1, 32'hA5A5A5A5, 32'h0,        0, 0);
        // low write keeps the unlock; key activity aborts but same-cycle protected write lands
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'h0032, 0, 32'hA5A5A5A5, 32'h0,        0, 0);
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'hFFCD, 0, 32'hA5A5A5A5, 32'h0,        1, 0);
        add(0, 0, 0,  1, 2,  32'h44444444, 0, 16'h0000, 0, 32'hA5A5A5A5, 32'h0,        1, 0);
        add(0, 0, 0,  1, 12, 32'h55555555, 1, 16'h1234, 0, 32'hA5A5A5A5, 32'h0,        0, 0);
        add(1, 12, 2, 0, 0,  32'h0,        0, 16'h0000, 1, 32'h55555555, 32'h44444444, 0, 0);
        // wrong second key, then stray ~KEY while LOCKED
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'h0032, 0, 32'h55555555, 32'h44444444, 0, 0);
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'h0000, 0, 32'h55555555, 32'h44444444, 0, 0);
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'hFFCD, 0, 32'h55555555, 32'h44444444, 0, 0);
        add(1, 12, 12, 1, 12, 32'h66666666, 0, 16'h0000, 1, 32'h55555555, 32'h55555555, 0, 1);
        // ARMED with no key on the next cycle drops back to LOCKED
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'h0032, 0, 32'h55555555, 32'h55555555, 0, 0);
        add(0, 0, 0,  0, 0,  32'h0,        0, 16'h0000, 0, 32'h55555555, 32'h55555555, 0, 0);
        add(0, 0, 0,  0, 0,  32'h0,        1, 16'hFFCD, 0, 32'h55555555, 32'h55555555, 0, 0);

        rst_n = 1'b0;
        idle();
        cyc();
        cyc();
        chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            drive(vecs[i].rd_en, vecs[i].a0, vecs[i].a1, vecs[i].wr_en, vecs[i].wa,
                  vecs[i].wd, vecs[i].kv, vecs[i].key);
            cyc();
            chk_all($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_d0, vecs[i].e_d1,
                    vecs[i].e_ka, vecs[i].e_err);
        end

        // reset while ARMED: immediate LOCKED, pending write lost, storage cleared
        @(negedge clk);
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 16'h0032);
        cyc();
        chk("armed key_access", 32'(key_access), 32'h0);
        @(negedge clk);
        drive(1'b1, 4'd3, 4'd3, 1'b1, 4'd3, 32'h77777777, 1'b1, 16'hFFCD);
        rst_n = 1'b0;
        #1;
        chk_all("armed_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        chk_all("armed_rst_edge", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'd3, 4'd12, 1'b0, 4'd0, 32'h0, 1'b1, 16'hFFCD);
        cyc();
        chk_all("post_rst_read", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

        // reset while UNLOCKED
        @(negedge clk);
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 16'h0032);
        cyc();
        @(negedge clk);
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 16'hFFCD);
        cyc();
        chk("unlocked key_access", 32'(key_access), 32'h1);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        chk("unlocked_rst key_access", 32'(key_access), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd13, 32'h88888888, 1'b0, 16'h0);
        cyc();
        chk("relock wr_err", 32'(wr_err), 32'h1);
        @(negedge clk);
        drive(1'b1, 4'd13, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 16'h0);
        cyc();
        chk("relock rd_data0", rd_data0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
